// File: rtl/paddsb_reduce_seq_pkg.sv
// Shared types and constants for the PADDSB reduction sequencer.
// Holds the FSM state enum and the nibble-lane saturation constants.
package paddsb_reduce_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 4;

  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/paddsb_sat16.sv
// Four-lane signed saturating nibble adder (PADDSB), purely combinational.
// Ports: a, b [15:0] operands; sum [15:0] clamped result; sat [3:0] clamp per lane.
module paddsb_sat16
  import paddsb_reduce_seq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic [3:0]  sat
);

  logic [LANE_W-1:0] la, lb, ls;
  logic              ovf, unf;

  always_comb begin
    sum = '0;
    sat = '0;
    la  = '0;
    lb  = '0;
    ls  = '0;
    ovf = 1'b0;
    unf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      la  = a[i*LANE_W +: LANE_W];
      lb  = b[i*LANE_W +: LANE_W];
      ls  = la + lb;
      // Clamp only when both signs agree and the sum flips sign;
      // lanes never carry into each other.
      ovf = ~la[3] & ~lb[3] &  ls[3];
      unf =  la[3] &  lb[3] & ~ls[3];
      unique case (1'b1)
        ovf:     sum[i*LANE_W +: LANE_W] = SAT_POS;
        unf:     sum[i*LANE_W +: LANE_W] = SAT_NEG;
        default: sum[i*LANE_W +: LANE_W] = ls;
      endcase
      sat[i] = ovf | unf;
    end
  end

endmodule

// File: rtl/paddsb_reduce_seq.sv
// Sequencer reducing a stream of packed operands with repeated PADDSB.
// Ports: start/len job request, in_* operand handshake, out_* result
// handshake, result/sat_flags outputs, busy status; async active-high rst.
module paddsb_reduce_seq
  import paddsb_reduce_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [3:0]       sat_flags
);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       flg_q, flg_d;

  logic [15:0] add_sum;
  logic [3:0]  add_sat;

  paddsb_sat16 u_sat16 (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          flg_d   = '0;
          cnt_d   = len;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          flg_d = flg_q | add_sat;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign sat_flags = flg_q;

endmodule

// File: tb/tb_paddsb_reduce_seq.sv
// Self-checking bench for paddsb_reduce_seq.
// Directed test-plan jobs plus random jobs against a lane-arithmetic model.
module tb_paddsb_reduce_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  sat_flags;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ops [16];
  logic [15:0] m_res;
  logic [3:0]  m_flg;

  always #5 clk = ~clk;

  paddsb_reduce_seq #(.LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat_flags (sat_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Signed integer add per lane, clamped to [-8, 7].
  function automatic logic [19:0] mdl_add(input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  f;
    int va, vb, vs;
    s = '0;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      va = $signed(a[i*4 +: 4]);
      vb = $signed(b[i*4 +: 4]);
      vs = va + vb;
      if (vs > 7) begin
        vs = 7;
        f[i] = 1'b1;
      end else if (vs < -8) begin
        vs = -8;
        f[i] = 1'b1;
      end
      s[i*4 +: 4] = vs[3:0];
    end
    return {f, s};
  endfunction

  // smode: 0 no stalls, 1 three stall cycles before op 1, 2 random.
  task automatic run_job(input int n, input int smode, input int hold);
    logic [19:0] r;
    int st;
    m_res = '0;
    m_flg = '0;
    start = 1'b1;
    len   = n[3:0];
    tick;
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("ov_start", out_valid, (n == 0));
    chk("rdy_start", in_ready, (n != 0));
    for (int i = 0; i < n; i++) begin
      st = 0;
      if (smode == 1 && i == 1) st = 3;
      if (smode == 2) st = $urandom_range(0, 2);
      for (int k = 0; k < st; k++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick;
        chk("stall_rdy", in_ready, 1);
        chk("stall_busy", busy, 1);
        chk("stall_ov", out_valid, 0);
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      r     = mdl_add(m_res, ops[i]);
      m_res = r[15:0];
      m_flg = m_flg | r[19:16];
      tick;
      in_valid = 1'b0;
      if (i < n - 1) chk("mid_ov", out_valid, 0);
    end
    chk("done_ov", out_valid, 1);
    chk("done_rdy", in_ready, 0);
    chk("result", result, m_res);
    chk("flags", sat_flags, m_flg);
    for (int k = 0; k < hold; k++) begin
      start = (k == 2);
      len   = 4'd3;
      tick;
      chk("hold_ov", out_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_res", result, m_res);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_ov", out_valid, 0);
    chk("idle_rdy", in_ready, 0);
    chk("idle_res", result, m_res);
    chk("idle_flg", sat_flags, m_flg);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flg", sat_flags, 0);
    rst = 1'b0;
    tick;

    ops[0] = 16'h1234; ops[1] = 16'h1111;
    run_job(2, 0, 0);
    chk("t1_res", result, 16'h2345);
    chk("t1_flg", sat_flags, 4'h0);

    ops[0] = 16'h7777;
    run_job(1, 0, 0);
    chk("t2a_res", result, 16'h7777);
    ops[0] = 16'h7777; ops[1] = 16'h1111;
    run_job(2, 0, 0);
    chk("t2b_res", result, 16'h7777);
    chk("t2b_flg", sat_flags, 4'hF);

    ops[0] = 16'h8888; ops[1] = 16'hFFFF;
    run_job(2, 0, 0);
    chk("t3_res", result, 16'h8888);
    chk("t3_flg", sat_flags, 4'hF);

    ops[0] = 16'h0004; ops[1] = 16'h0004; ops[2] = 16'h0004;
    run_job(3, 0, 0);
    chk("t4_res", result, 16'h0007);
    chk("t4_flg", sat_flags, 4'h1);

    ops[0] = 16'h7F00; ops[1] = 16'h8100;
    run_job(2, 0, 0);
    chk("t5_res", result, 16'hF000);
    chk("t5_flg", sat_flags, 4'h0);

    for (int i = 0; i < 4; i++) ops[i] = 16'h3210 + 16'(i);
    run_job(4, 1, 5);

    run_job(0, 0, 0);
    chk("len0_res", result, 16'h0000);
    chk("len0_flg", sat_flags, 4'h0);

    // Abort mid-job with an asynchronous reset.
    ops[0] = 16'h5555; ops[1] = 16'h2222;
    start = 1'b1;
    len   = 4'd5;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_res", result, 0);
    chk("abort_flg", sat_flags, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("post_busy", busy, 0);

    for (int j = 0; j < 40; j++) begin
      int n;
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        ops[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) ops[i] = ops[i] & 16'h7777;
      end
      run_job(n, 2, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/paddsb_reduce_seq.md
# paddsb_reduce_seq

Sequencer that reduces a stream of 16-bit packed operands into one result using nibble-wise signed saturating addition, i.e. repeated PADDSB. It sits beside the ALU and lets software run multi-operand PADDSB accumulations without a round trip through the register file. Input and output use valid/ready handshakes. Per-nibble saturation events are reported as sticky flags.

## Interface
- `LEN_W`, default 4: width of the operand-count field; at most 2^LEN_W-1 operands per job.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  operands in the job, sampled with `start`; 0 is legal.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  high only in ACCUM.
- `in_data`  in  16  packed operand, four signed 4-bit lanes; lane 0 = [3:0].
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  16  accumulated packed value, held stable while `out_valid`.
- `sat_flags`  out  4  sticky per-lane saturation flags for the current job, bit i = lane i.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is two bits.
- Reset values: state IDLE, accumulator 0x0000, count 0, `sat_flags` 0, `busy` 0, `in_ready` 0, `out_valid` 0.
- **IDLE**
  - On `start` with `len`≠0: clear the accumulator and `sat_flags`, load count=`len`, go to ACCUM.
  - On `start` with `len`=0: clear the accumulator and `sat_flags`, go directly to DONE. The result is 0x0000.
- **ACCUM**
  - A transfer occurs on each cycle with `in_valid` && `in_ready`.
  - On a transfer: acc <= sat_add(acc, `in_data`); `sat_flags` |= lane saturation bits; count decrements.
  - The transfer that takes count from 1 to 0 also moves the state to DONE.
  - Cycles without `in_valid` are stalls: no state change.
- **DONE**
  - `out_valid`=1 and `result`=acc.
  - On `out_ready`: go to IDLE.
  - `result` and `sat_flags` keep their values in IDLE until the next `start`.
- `start` outside IDLE is ignored; it is not queued.
- Lane arithmetic: 4-bit two's complement add.
  - If both inputs have sign 0 and the sum has sign 1 (overflow), the lane result is 0x7.
  - If both inputs have sign 1 and the sum has sign 0 (underflow), the lane result is 0x8.
  - Otherwise the lane result is the wrapped sum.
  - The saturation bit for a lane is 1 exactly when clamping occurred in that lane.
  - There is no carry between lanes.
- Reset asserted in any state aborts the job immediately. Any partial result is discarded.

## Timing
- `start` to `in_ready`: 1 cycle.
- Last operand transfer to `out_valid`: 1 cycle. The result is registered; there is no combinational path from `in_data` to `result`.
- `start` with `len`=0 to `out_valid`: 1 cycle.
- Maximum throughput: 1 operand per cycle. A job of N operands with no stalls takes N+1 cycles from `start` to `out_valid`.
- DONE to IDLE on the `out_ready` edge. A new `start` is accepted on the following cycle at the earliest.
- `in_ready` and `out_valid` are decoded from the state register only. Neither depends combinationally on `in_valid` or `out_ready`.

## Structure
- Shared package holds:
  - the state enum (IDLE, ACCUM, DONE);
  - lane constants SAT_POS=4'h7 and SAT_NEG=4'h8;
  - lane count 4 and lane width 4.
- One combinational sub-module `paddsb_sat16`, shared with the ALU. Inputs: a, b [15:0]. Outputs: sum [15:0] and sat [3:0].
- The sequencer holds the FSM, the count, the accumulator and the flag registers.

## Test plan
- len=2, operands 0x1234 then 0x1111 → `result`=0x2345, `sat_flags`=0x0, `out_valid` 3 cycles after `start` with no stalls.
- len=1, operand 0x7777 from a cleared accumulator, then a second job with len=2, operands 0x7777 and 0x1111 → `result`=0x7777, `sat_flags`=0xF. Also len=2, operands 0x8888 and 0xFFFF → `result`=0x8888, `sat_flags`=0xF.
- len=3, operand 0x0004 three times → `result`=0x0007, `sat_flags`=0x1. Check that the lane-0 clamp holds on the third add.
- len=2, operands 0x7F00 and 0x8100 → `result`=0xF000, `sat_flags`=0x0. Mixed-sign lanes wrap and never clamp.
- Backpressure case:
  - drop `in_valid` for 3 cycles mid-job → count does not advance;
  - in DONE, hold `out_ready` low for 5 cycles and pulse `start` → `result` stays stable and `start` is ignored;
  - `busy` stays 1 throughout.
- Corner cases:
  - len=0 → `out_valid` on the next cycle with `result`=0x0000;
  - assert `rst` mid-ACCUM → next cycle shows IDLE with all outputs at reset values.
